// File: rtl/decision.sv
// decision: pulse-width measure-and-compare block.
// Counts clk cycles while timer is high. On a register rising edge it
// stores the measurement as the new reference. comp reports whether
// that measurement was strictly longer than the previous reference.
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active low
//   timer      in   1      pulse to measure (high = counting)
//   register   in   1      capture strobe, acts on rising edge only
//   out_timer  out  WIDTH  live / last measured pulse length
//   out_reg    out  WIDTH  stored reference measurement
//   comp       out  1      last capture was > previous reference
module decision #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer,
    input  logic             register,
    output logic [WIDTH-1:0] out_timer,
    output logic [WIDTH-1:0] out_reg,
    output logic             comp
);

    logic             r_timer_d;
    logic             r_register_d;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_ref;
    logic             r_comp;

    logic             w_timer_rise;
    logic             w_reg_rise;
    logic             w_count_max;

    assign w_timer_rise = timer & ~r_timer_d;
    assign w_reg_rise   = register & ~r_register_d;
    assign w_count_max  = (r_count == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer_d    <= 1'b0;
            r_register_d <= 1'b0;
            r_count      <= '0;
            r_ref        <= '0;
            r_comp       <= 1'b0;
        end else begin
            r_timer_d    <= timer;
            r_register_d <= register;

            // A fresh rising edge restarts at 1 so a pulse of N edges
            // reads N; the count saturates instead of wrapping.
            if (w_timer_rise) begin
                r_count <= {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (timer && !w_count_max) begin
                r_count <= r_count + 1'b1;
            end

            // Capture sees the pre-edge count, even mid-pulse.
            if (w_reg_rise) begin
                r_comp <= (r_count > r_ref);
                r_ref  <= r_count;
            end
        end
    end

    assign out_timer = r_count;
    assign out_reg   = r_ref;
    assign comp      = r_comp;

endmodule

// File: tb/tb_decision.sv
// tb_decision: scoreboard bench for decision.
// Runs a 20-bit and a 4-bit instance side by side on the same stimulus.
module tb_decision;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer;
    logic        register;
    logic [19:0] ot_w;
    logic [19:0] or_w;
    logic        cp_w;
    logic [3:0]  ot_n;
    logic [3:0]  or_n;
    logic        cp_n;

    int n_chk = 0;
    int n_bad = 0;

    always #1 clk = ~clk;

    decision #(.WIDTH(20)) u_wide (
        .clk       (clk),
        .rst       (rst),
        .timer     (timer),
        .register  (register),
        .out_timer (ot_w),
        .out_reg   (or_w),
        .comp      (cp_w)
    );

    decision #(.WIDTH(4)) u_narrow (
        .clk       (clk),
        .rst       (rst),
        .timer     (timer),
        .register  (register),
        .out_timer (ot_n),
        .out_reg   (or_n),
        .comp      (cp_n)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    // Expected values per instance: index 0 = 20-bit, 1 = 4-bit.
    int unsigned e_t[2];
    int unsigned e_r[2];
    int unsigned e_c[2];
    int unsigned e_max[2];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(int kind);
        case (kind)
            0: obs = {12'd0, ot_w};
            1: obs = {12'd0, or_w};
            2: obs = {31'd0, cp_w};
            3: obs = {28'd0, ot_n};
            4: obs = {28'd0, or_n};
            default: obs = {31'd0, cp_n};
        endcase
    endfunction

    function automatic void push_all(string phase);
        string nm[2];
        nm[0] = "w";
        nm[1] = "n";
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{$sformatf("%s.%s.timer", phase, nm[i]),
                             3*i, e_t[i]});
            sb_q.push_back('{$sformatf("%s.%s.reg", phase, nm[i]),
                             3*i+1, e_r[i]});
            sb_q.push_back('{$sformatf("%s.%s.comp", phase, nm[i]),
                             3*i+2, e_c[i]});
        end
    endfunction

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs(e.kind), e.exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            e_t[i] = 0;
            e_r[i] = 0;
            e_c[i] = 0;
        end
    endfunction

    function automatic void m_count(int unsigned n);
        for (int i = 0; i < 2; i++)
            e_t[i] = (n > e_max[i]) ? e_max[i] : n;
    endfunction

    function automatic void m_capture();
        for (int i = 0; i < 2; i++) begin
            e_c[i] = (e_t[i] > e_r[i]) ? 1 : 0;
            e_r[i] = e_t[i];
        end
    endfunction

    // Called on a negedge; ends on a negedge with timer low.
    task automatic pulse(int n);
        timer = 1'b1;
        repeat (n) @(negedge clk);
        timer = 1'b0;
        m_count(n);
        @(negedge clk);
    endtask

    task automatic capture(int k);
        register = 1'b1;
        m_capture();
        repeat (k) @(negedge clk);
        register = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_max[0] = 32'hFFFFF;
        e_max[1] = 15;
        rst      = 1'b0;
        timer    = 1'b0;
        register = 1'b0;
        m_reset();

        // 1: reset held while inputs toggle
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            push_all($sformatf("rst%0d", c));
            drain();
            timer    = ~timer;
            register = ~register;
        end
        timer    = 1'b0;
        register = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_all("post_rst");
        drain();

        // 2: 50-cycle pulse then capture
        pulse(50);
        push_all("p50_count");
        drain();
        capture(1);
        push_all("p50_cap");
        drain();

        // 3: 100-cycle pulse then capture
        pulse(100);
        capture(1);
        push_all("p100_cap");
        drain();

        // 4: 50-cycle pulse, register held 2 cycles
        pulse(50);
        capture(2);
        push_all("p50_hold2");
        drain();

        // 4b: register held during a running pulse, one capture only
        register = 1'b1;
        timer    = 1'b1;
        m_capture();
        repeat (20) @(negedge clk);
        m_count(20);
        push_all("hold_run");
        drain();
        register = 1'b0;
        timer    = 1'b0;
        @(negedge clk);
        push_all("hold_rel");
        drain();

        // 5: equal 50-cycle measurement gives comp=0
        pulse(50);
        capture(1);
        push_all("p50_eq");
        drain();

        // 5b: reset in the middle of a pulse
        timer = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_reset();
        push_all("mid_rst");
        drain();
        rst   = 1'b1;
        timer = 1'b0;
        repeat (3) @(negedge clk);
        push_all("rst_idle");
        drain();
        pulse(7);
        push_all("p7_count");
        drain();
        capture(1);
        push_all("p7_cap");
        drain();

        // 6: 20-cycle pulse saturates the 4-bit counter at 15
        pulse(20);
        push_all("p20_sat");
        drain();
        capture(1);
        push_all("p20_cap");
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
